// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter_if                                                     |
// | Fetch port, data port and shared-memory port bundled for           |
// | mem_arbiter.                                                       |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface mem_arbiter_if;
   // fetch (instruction) port
   logic        i_imem_req;
   logic [31:0] i_imem_addr;
   logic        o_imem_ready;
   logic        o_imem_valid;
   logic [31:0] o_imem_rdata;

   // data port
   logic        i_dmem_req;
   logic        i_dmem_wen;
   logic [31:0] i_dmem_addr;
   logic [31:0] i_dmem_wdata;
   logic [3:0]  i_dmem_mask;
   logic        o_dmem_ready;
   logic        o_dmem_valid;
   logic [31:0] o_dmem_rdata;

   // shared memory port
   logic        o_mem_req;
   logic        o_mem_wen;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_mask;
   logic        i_mem_ready;
   logic        i_mem_valid;
   logic [31:0] i_mem_rdata;

   // Arbiter side: reads both requesters and the memory, drives every o_* signal.
   modport slave (
      input  i_imem_req, i_imem_addr,
      output o_imem_ready, o_imem_valid, o_imem_rdata,
      input  i_dmem_req, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
      output o_dmem_ready, o_dmem_valid, o_dmem_rdata,
      output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
      input  i_mem_ready, i_mem_valid, i_mem_rdata
   );

   // Environment side: the two requesters plus the shared memory.
   modport master (
      output i_imem_req, i_imem_addr,
      input  o_imem_ready, o_imem_valid, o_imem_rdata,
      output i_dmem_req, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
      input  o_dmem_ready, o_dmem_valid, o_dmem_rdata,
      input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
      output i_mem_ready, i_mem_valid, i_mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arbiter                                                        |
// | Two-port (fetch / data) arbiter in front of a single-outstanding   |
// | shared memory. Data wins contention until it has taken FAIR_LIMIT  |
// | contested grants in a row, then fetch is served once.              |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module mem_arbiter #(
   parameter int FAIR_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   // counter must be able to hold FAIR_LIMIT itself
   localparam int             CW         = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
   localparam logic [CW-1:0]  LIMIT      = CW'(FAIR_LIMIT);
   localparam logic [3:0]     FETCH_MASK = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t        state;
   logic          owner_dmem;      // 1: data port owns the access in flight
   logic [CW-1:0] fair_cnt;        // consecutive contested data grants

   // request fields captured on the grant cycle and presented to memory
   logic          mem_req_q;
   logic          mem_wen_q;
   logic [29:0]   mem_word_q;      // word address; byte offset is always zero
   logic [31:0]   mem_wdata_q;
   logic [3:0]    mem_mask_q;

   logic          grant_dmem;
   logic          grant_imem;
   logic          imem_starved;
   logic          resp;

   // Pick a winner while idle; data wins contention until fetch's turn is due.
   always_comb begin
      grant_dmem   = 1'b0;
      grant_imem   = 1'b0;
      imem_starved = (fair_cnt == LIMIT);
      if (!rst && state == IDLE) begin
         if (bus.i_dmem_req && !(bus.i_imem_req && imem_starved)) begin
            grant_dmem = 1'b1;
         end else if (bus.i_imem_req) begin
            grant_imem = 1'b1;
         end
      end
   end

   // Access sequencer: grant/latch in IDLE, hold the request in ISSUE, await data in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner_dmem  <= 1'b0;
         fair_cnt    <= '0;
         mem_req_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_word_q  <= '0;
         mem_wdata_q <= '0;
         mem_mask_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_dmem) begin
                  owner_dmem  <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_wen_q   <= bus.i_dmem_wen;
                  mem_word_q  <= bus.i_dmem_addr[31:2];
                  mem_wdata_q <= bus.i_dmem_wdata;
                  mem_mask_q  <= bus.i_dmem_mask;
                  // only contested grants count toward starving fetch
                  if (bus.i_imem_req && !imem_starved) begin
                     fair_cnt <= fair_cnt + CW'(1);
                  end
                  state <= ISSUE;
               end else if (grant_imem) begin
                  owner_dmem  <= 1'b0;
                  mem_req_q   <= 1'b1;
                  mem_wen_q   <= 1'b0;
                  mem_word_q  <= bus.i_imem_addr[31:2];
                  mem_wdata_q <= '0;
                  mem_mask_q  <= FETCH_MASK;
                  fair_cnt    <= '0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // fields stay frozen until memory takes the request
               if (bus.i_mem_ready) begin
                  mem_req_q   <= 1'b0;
                  mem_wen_q   <= 1'b0;
                  mem_word_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_mask_q  <= '0;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (bus.i_mem_valid) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Completion is only recognised while an access is outstanding.
   assign resp = !rst && (state == WAIT) && bus.i_mem_valid;

   // Ready must coincide with the grant cycle so requesters can release
   // their request immediately; it is therefore decoded, not registered.
   assign bus.o_imem_ready = grant_imem;
   assign bus.o_dmem_ready = grant_dmem;

   // Response is a same-cycle pass-through of the memory completion.
   assign bus.o_imem_valid = resp && !owner_dmem;
   assign bus.o_dmem_valid = resp &&  owner_dmem;
   assign bus.o_imem_rdata = bus.o_imem_valid ? bus.i_mem_rdata : 32'd0;
   assign bus.o_dmem_rdata = bus.o_dmem_valid ? bus.i_mem_rdata : 32'd0;

   // Memory request; reset forces the bus quiet before the first edge.
   assign bus.o_mem_req   = mem_req_q && !rst;
   assign bus.o_mem_wen   = mem_wen_q && !rst;
   assign bus.o_mem_addr  = rst ? 32'd0 : {mem_word_q, 2'b00};
   assign bus.o_mem_wdata = rst ? 32'd0 : mem_wdata_q;
   assign bus.o_mem_mask  = rst ? 4'd0  : mem_mask_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_arbiter                                                     |
// | Self-checking bench: directed scenarios plus randomized traffic    |
// | compared against a transaction-level model of the arbiter.         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;
   localparam int FAIR_LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // transaction-level reference: is an access in flight, has memory taken it
   bit          m_busy  = 1'b0;
   bit          m_sent  = 1'b0;
   bit          m_own_d = 1'b0;
   bit          m_wen   = 1'b0;
   int          m_cnt   = 0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_mask  = '0;

   // observations from the most recent step
   bit          g_i, g_d;
   int          cyc = 0;
   int          last_grant_cyc = 0;
   int          grant_gap = 0;
   logic [31:0] grant_bits = '0;   // shift register of grants, 1 = data
   int          iv_pulses = 0;
   int          dv_pulses = 0;
   logic        s_req, s_wen, s_iready;
   logic [31:0] s_addr, s_wdata, s_irdata;
   logic [3:0]  s_mask;

   // random requesters: a raised request is held until granted
   bit rp_i = 1'b0;
   bit rp_d = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.i_imem_req   = 1'b0;
      bus.i_imem_addr  = '0;
      bus.i_dmem_req   = 1'b0;
      bus.i_dmem_wen   = 1'b0;
      bus.i_dmem_addr  = '0;
      bus.i_dmem_wdata = '0;
      bus.i_dmem_mask  = '0;
      bus.i_mem_ready  = 1'b0;
      bus.i_mem_valid  = 1'b0;
      bus.i_mem_rdata  = '0;
   endtask

   // One clock: inputs already driven; sample mid-cycle, compare, then advance model.
   task automatic step();
      bit eg_d, eg_i, resp;
      eg_d = 1'b0;
      eg_i = 1'b0;
      resp = 1'b0;
      #3;
      s_req    = bus.o_mem_req;
      s_wen    = bus.o_mem_wen;
      s_addr   = bus.o_mem_addr;
      s_wdata  = bus.o_mem_wdata;
      s_mask   = bus.o_mem_mask;
      s_iready = bus.o_imem_ready;
      s_irdata = bus.o_imem_rdata;
      if (bus.o_imem_valid) iv_pulses++;
      if (bus.o_dmem_valid) dv_pulses++;
      if (rst) begin
         check("rst_ctl", {26'd0, bus.o_imem_ready, bus.o_dmem_ready, bus.o_imem_valid,
                           bus.o_dmem_valid, bus.o_mem_req, bus.o_mem_wen}, 32'd0);
         check("rst_mem_addr", bus.o_mem_addr, 32'd0);
         check("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
         check("rst_mem_mask", 32'(bus.o_mem_mask), 32'd0);
         check("rst_rdata", bus.o_imem_rdata | bus.o_dmem_rdata, 32'd0);
      end else begin
         eg_d = !m_busy && bus.i_dmem_req && !(bus.i_imem_req && m_cnt == FAIR_LIMIT);
         eg_i = !m_busy && bus.i_imem_req && !eg_d;
         resp = m_busy && m_sent && bus.i_mem_valid;
         check("dmem_ready", 32'(bus.o_dmem_ready), 32'(eg_d));
         check("imem_ready", 32'(bus.o_imem_ready), 32'(eg_i));
         check("mem_req", 32'(bus.o_mem_req), 32'(m_busy && !m_sent));
         if (m_busy && !m_sent) begin
            check("mem_wen", 32'(bus.o_mem_wen), 32'(m_wen));
            check("mem_addr", bus.o_mem_addr, m_addr);
            check("mem_mask", 32'(bus.o_mem_mask), 32'(m_mask));
            if (m_own_d) check("mem_wdata", bus.o_mem_wdata, m_wdata);
         end
         check("imem_valid", 32'(bus.o_imem_valid), 32'(resp && !m_own_d));
         check("dmem_valid", 32'(bus.o_dmem_valid), 32'(resp && m_own_d));
         if (resp && !m_own_d) check("imem_rdata", bus.o_imem_rdata, bus.i_mem_rdata);
         if (resp && m_own_d && !m_wen) check("dmem_rdata", bus.o_dmem_rdata, bus.i_mem_rdata);
      end
      @(posedge clk);
      cyc++;
      g_i = eg_i;
      g_d = eg_d;
      if (eg_i || eg_d) begin
         grant_gap      = cyc - last_grant_cyc;
         last_grant_cyc = cyc;
         grant_bits     = {grant_bits[30:0], eg_d};
      end
      if (rst) begin
         m_busy = 1'b0;
         m_sent = 1'b0;
         m_cnt  = 0;
      end else if (eg_d) begin
         m_busy  = 1'b1;
         m_sent  = 1'b0;
         m_own_d = 1'b1;
         m_wen   = bus.i_dmem_wen;
         m_addr  = {bus.i_dmem_addr[31:2], 2'b00};
         m_wdata = bus.i_dmem_wdata;
         m_mask  = bus.i_dmem_mask;
         if (bus.i_imem_req && m_cnt < FAIR_LIMIT) m_cnt++;
      end else if (eg_i) begin
         m_busy  = 1'b1;
         m_sent  = 1'b0;
         m_own_d = 1'b0;
         m_wen   = 1'b0;
         m_addr  = {bus.i_imem_addr[31:2], 2'b00};
         m_mask  = 4'b1111;
         m_cnt   = 0;
      end else if (m_busy && !m_sent && bus.i_mem_ready) begin
         m_sent = 1'b1;
      end else if (resp) begin
         m_busy = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic rand_cycle();
      rst = ($urandom_range(0, 199) == 0);
      if (!rp_i) begin
         bus.i_imem_addr = $urandom;
         rp_i = ($urandom_range(0, 2) == 0);
      end
      if (!rp_d) begin
         bus.i_dmem_wen   = 1'($urandom_range(0, 1));
         bus.i_dmem_addr  = $urandom;
         bus.i_dmem_wdata = $urandom;
         bus.i_dmem_mask  = 4'($urandom);
         rp_d = ($urandom_range(0, 2) == 0);
      end
      bus.i_imem_req  = rp_i;
      bus.i_dmem_req  = rp_d;
      bus.i_mem_ready = ($urandom_range(0, 1) == 1);
      bus.i_mem_valid = ($urandom_range(0, 2) == 0);
      bus.i_mem_rdata = $urandom;
      step();
      if (g_i) rp_i = 1'b0;
      if (g_d) rp_d = 1'b0;
   endtask

   initial begin
      int ng;
      logic [31:0] d_addr, d_wdata;
      logic [3:0]  d_mask;

      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // single fetch, unaligned address, memory ready at once, data two cycles later
      bus.i_imem_req  = 1'b1;
      bus.i_imem_addr = 32'h0000_1006;
      step();
      check("fetch_granted", 32'(s_iready), 32'd1);
      bus.i_imem_req  = 1'b0;
      bus.i_imem_addr = 32'hFFFF_FFFF;
      bus.i_mem_ready = 1'b1;
      step();
      check("fetch_mem_req", 32'(s_req), 32'd1);
      check("fetch_addr", s_addr, 32'h0000_1004);
      check("fetch_mask", 32'(s_mask), 32'hF);
      check("fetch_wen", 32'(s_wen), 32'd0);
      bus.i_mem_ready = 1'b0;
      iv_pulses = 0;
      dv_pulses = 0;
      step();
      bus.i_mem_valid = 1'b1;
      bus.i_mem_rdata = 32'hDEAD_BEEF;
      step();
      check("fetch_rdata", s_irdata, 32'hDEAD_BEEF);
      bus.i_mem_valid = 1'b0;
      step();
      check("fetch_ivalid_pulses", 32'(iv_pulses), 32'd1);
      check("fetch_dvalid_pulses", 32'(dv_pulses), 32'd0);

      // continuous contention with a 1-cycle memory
      do_reset();
      grant_bits      = '0;
      bus.i_imem_req  = 1'b1;
      bus.i_dmem_req  = 1'b1;
      bus.i_mem_ready = 1'b1;
      bus.i_mem_valid = 1'b1;
      repeat (30) step();
      check("contention_order", grant_bits & 32'h3FF, 32'h3DE);

      // byte store, zero address offset forced
      do_reset();
      bus.i_dmem_req   = 1'b1;
      bus.i_dmem_wen   = 1'b1;
      bus.i_dmem_addr  = 32'h0000_2003;
      bus.i_dmem_wdata = 32'hAB00_0000;
      bus.i_dmem_mask  = 4'b1000;
      bus.i_mem_ready  = 1'b1;
      step();
      bus.i_dmem_req   = 1'b0;
      bus.i_dmem_wen   = 1'b0;
      bus.i_dmem_addr  = 32'h1234_5678;
      step();
      check("store_addr", s_addr, 32'h0000_2000);
      check("store_wdata", s_wdata, 32'hAB00_0000);
      check("store_mask", 32'(s_mask), 32'h8);
      check("store_wen", 32'(s_wen), 32'd1);
      bus.i_mem_ready = 1'b0;
      iv_pulses = 0;
      dv_pulses = 0;
      bus.i_mem_valid = 1'b1;
      step();
      bus.i_mem_valid = 1'b0;
      step();
      check("store_dvalid_pulses", 32'(dv_pulses), 32'd1);
      check("store_ivalid_pulses", 32'(iv_pulses), 32'd0);

      // backpressure with requester inputs churning
      do_reset();
      d_addr  = 32'h0000_5A5C;
      d_wdata = 32'hCAFE_F00D;
      d_mask  = 4'b0000;   // empty mask must still go through
      bus.i_dmem_req   = 1'b1;
      bus.i_dmem_wen   = 1'b1;
      bus.i_dmem_addr  = d_addr;
      bus.i_dmem_wdata = d_wdata;
      bus.i_dmem_mask  = d_mask;
      step();
      repeat (5) begin
         bus.i_dmem_req   = 1'($urandom_range(0, 1));
         bus.i_dmem_wen   = 1'($urandom_range(0, 1));
         bus.i_dmem_addr  = $urandom;
         bus.i_dmem_wdata = $urandom;
         bus.i_dmem_mask  = 4'($urandom);
         bus.i_imem_req   = 1'($urandom_range(0, 1));
         bus.i_imem_addr  = $urandom;
         step();
         check("bp_req", 32'(s_req), 32'd1);
         check("bp_addr", s_addr, d_addr);
         check("bp_wdata", s_wdata, d_wdata);
         check("bp_mask", 32'(s_mask), 32'(d_mask));
      end
      bus.i_mem_ready = 1'b1;
      step();
      check("bp_accept_addr", s_addr, d_addr);
      idle_inputs();
      dv_pulses = 0;
      bus.i_mem_valid = 1'b1;
      step();
      check("bp_complete", 32'(dv_pulses), 32'd1);

      // reset while waiting; a late completion must be ignored
      do_reset();
      bus.i_imem_req  = 1'b1;
      bus.i_imem_addr = 32'h0000_3000;
      bus.i_mem_ready = 1'b1;
      step();
      bus.i_imem_req  = 1'b0;
      step();
      bus.i_mem_ready = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      iv_pulses = 0;
      dv_pulses = 0;
      bus.i_mem_valid = 1'b1;
      step();
      check("late_valid_ignored", 32'(iv_pulses + dv_pulses), 32'd0);
      bus.i_mem_valid = 1'b0;
      bus.i_imem_req  = 1'b1;
      bus.i_imem_addr = 32'h0000_4000;
      step();
      check("post_reset_grant", 32'(s_iready), 32'd1);
      bus.i_imem_req  = 1'b0;
      bus.i_mem_ready = 1'b1;
      step();
      check("post_reset_addr", s_addr, 32'h0000_4000);
      bus.i_mem_ready = 1'b0;
      bus.i_mem_valid = 1'b1;
      step();
      check("post_reset_done", 32'(iv_pulses), 32'd1);

      // back-to-back fetches every 3 cycles; counter must not move
      do_reset();
      ng = 0;
      bus.i_imem_req  = 1'b1;
      bus.i_mem_ready = 1'b1;
      bus.i_mem_valid = 1'b1;
      repeat (12) begin
         step();
         if (g_i) ng++;
      end
      check("b2b_grants", 32'(ng), 32'd4);
      check("b2b_gap", 32'(grant_gap), 32'd3);
      grant_bits     = '0;
      bus.i_dmem_req = 1'b1;
      repeat (15) step();
      check("b2b_counter_clear", grant_bits & 32'h1F, 32'h1E);

      // randomized traffic against the model
      do_reset();
      rp_i = 1'b0;
      rp_d = 1'b0;
      repeat (3000) rand_cycle();
      rst = 1'b0;
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FAIR_LIMIT, default 4, meaning the maximum number of consecutive contested dmem grants before imem is forced a grant.
REQ-002 SHALL have ports:
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  i_imem_req  in  1  fetch requests a read
  i_imem_addr  in  32  fetch byte address
  o_imem_ready  out  1  fetch request accepted this cycle
  o_imem_valid  out  1  fetch read data valid this cycle
  o_imem_rdata  out  32  fetch read data
  i_dmem_req  in  1  data port requests an access
  i_dmem_wen  in  1  1 = write, 0 = read
  i_dmem_addr  in  32  data byte address
  i_dmem_wdata  in  32  write data, already lane-shifted
  i_dmem_mask  in  4  byte-lane mask
  o_dmem_ready  out  1  data request accepted this cycle
  o_dmem_valid  out  1  data access complete this cycle; rdata valid for reads
  o_dmem_rdata  out  32  data read data
  o_mem_req  out  1  request to shared memory
  o_mem_wen  out  1  shared-memory write enable
  o_mem_addr  out  32  word-aligned address
  o_mem_wdata  out  32  write data
  o_mem_mask  out  4  byte mask; 4'b1111 for fetch
  i_mem_ready  in  1  memory accepts o_mem_req this cycle
  i_mem_valid  in  1  memory completes the outstanding access
  i_mem_rdata  in  32  memory read data

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, with at most one access outstanding.
REQ-004 IDLE: no request -> stay; any request -> grant one requester, latch its fields, pulse that requester's ready for 1 cycle, go to ISSUE next cycle.
REQ-005 Priority: dmem only -> dmem; imem only -> imem; both -> dmem, unless the contested-dmem counter equals FAIR_LIMIT, in which case imem.
REQ-006 Contested-dmem counter: +1 on dmem grant while i_imem_req=1, saturating at FAIR_LIMIT; cleared on any imem grant; unchanged otherwise.
REQ-007 ISSUE: o_mem_req=1 with latched fields, stable until i_mem_ready=1; then go to WAIT next cycle. i_mem_ready=1 in the first ISSUE cycle is legal.
REQ-008 o_mem_addr SHALL be the latched address with bits [1:0] forced to 0; fetch SHALL drive o_mem_wen=0 and o_mem_mask=4'b1111.
REQ-009 WAIT: on i_mem_valid=1, pulse the owner's valid for exactly that cycle, with rdata = i_mem_rdata (combinational pass-through), then go to IDLE; the non-owner's valid SHALL stay 0.
REQ-010 Writes SHALL also complete via i_mem_valid; o_dmem_valid pulses and o_dmem_rdata is don't-care.
REQ-011 i_mem_valid outside WAIT SHALL be ignored; it produces no valid pulse.
REQ-012 Requests not granted SHALL be held by the requester; the arbiter samples fields only on the grant cycle, so later changes do not affect the in-flight access.
REQ-013 Minimum turnaround SHALL be 3 cycles (grant, issue, response); a new grant can occur in the IDLE cycle after the response.
REQ-014 A write with i_dmem_mask=4'b0000 SHALL still be issued and completed normally.

Reset
REQ-015 While rst=1, the FSM SHALL enter IDLE, clear the counter and owner, and drive all outputs to 0 (ready, valid, o_mem_* and rdata outputs).
REQ-016 Reset asserted mid-access (ISSUE or WAIT) SHALL abandon the access; a late i_mem_valid after reset SHALL be ignored per REQ-011.

Verification
REQ-017 Single fetch: imem req addr 0x0000_1006, memory ready at once, valid 2 cycles later with 0xDEADBEEF -> o_mem_addr=0x0000_1004, mask 4'b1111, wen 0; o_imem_valid 1 cycle with 0xDEADBEEF.
REQ-018 Contention: both requesting continuously, FAIR_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-019 Byte store: dmem wen=1 addr 0x0000_2003 wdata 0xAB000000 mask 4'b1000 -> o_mem_addr 0x0000_2000, same wdata/mask, o_dmem_valid pulse, o_imem_valid stays 0.
REQ-020 Backpressure: i_mem_ready low for 5 cycles -> o_mem_req and all o_mem_* fields held stable for 5 cycles while requester inputs change; the access completes with the original fields.
REQ-021 Reset in WAIT, then i_mem_valid=1 one cycle after reset deasserts -> no valid pulse; the next imem request is granted normally.
REQ-022 Back-to-back: imem req held, 1-cycle memory -> grants every 3 cycles; counter stays 0.
